// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// One whole-line transaction at a time; the winner's command is latched until memory responds.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache side
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // Memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  // FSM state for checkers: 0 = IDLE, 1 = I_BUSY, 2 = D_BUSY
  output logic [1:0]            o_dbg_state
);

  // Handshake: a client holds read/write (and its address/data) until its resp pulse;
  // resp is high for exactly the one cycle in which pmem_resp arrives for the owner.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_BUSY = 2'd1,
    S_D_BUSY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_d;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [ADDR_WIDTH-1:0] r_pmem_address;
  logic [LINE_WIDTH-1:0] r_pmem_wdata;
  logic                  w_d_req;
  logic                  w_grant_i;
  logic                  w_grant_d;

  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Busy states always return through IDLE, so a client that drops its
  // request after resp can never be re-granted by accident.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_read && w_d_req) begin
          w_next_state = r_last_d ? S_I_BUSY : S_D_BUSY;
        end else if (i_read) begin
          w_next_state = S_I_BUSY;
        end else if (w_d_req) begin
          w_next_state = S_D_BUSY;
        end
      end
      S_I_BUSY: if (pmem_resp) w_next_state = S_IDLE;
      S_D_BUSY: if (pmem_resp) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    o_dbg_state = r_state;
    if (r_state == S_I_BUSY) i_resp = pmem_resp;
    if (r_state == S_D_BUSY) d_resp = pmem_resp;
  end

  assign w_grant_i = (r_state == S_IDLE) && (w_next_state == S_I_BUSY);
  assign w_grant_d = (r_state == S_IDLE) && (w_next_state == S_D_BUSY);

  // Command latch: loaded on the grant edge, held stable until completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d       <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else if (w_grant_i) begin
      r_last_d       <= 1'b0;
      r_pmem_read    <= 1'b1;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= i_address;
    end else if (w_grant_d) begin
      r_last_d       <= 1'b1;
      r_pmem_read    <= ~d_write;
      r_pmem_write   <= d_write;
      r_pmem_address <= d_address;
      r_pmem_wdata   <= d_wdata;
    end else if ((r_state != S_IDLE) && pmem_resp) begin
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: fills, write-back, round-robin contention,
// command stability, spurious responses and reset during a transaction.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_I    = 2'd1;
  localparam logic [1:0] ST_D    = 2'd2;
  localparam logic [LW-1:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] PAT_B = {8{32'h5A5A_0002}};
  localparam logic [LW-1:0] PAT_C = {8{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    n_tests++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    n_tests++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    n_tests++; if (pmem_address !== '0) begin n_fail++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
    n_tests++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
    n_tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_resp, d_resp); end
    n_tests++; if (o_dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", o_dbg_state, ST_IDLE); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_i_fill();
    i_read    = 1'b1;
    i_address = 32'h0000_1000;
    tick(); // cycle 1: command visible
    n_tests++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL ifill_cmd: got r=%b w=%b want r=1 w=0", pmem_read, pmem_write); end
    n_tests++; if (pmem_address !== 32'h0000_1000) begin n_fail++; $display("FAIL ifill_addr: got %h want 00001000", pmem_address); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_tests++; if (pmem_read !== 1'b1 || i_resp !== 1'b0) begin n_fail++; $display("FAIL ifill_wait c%0d: got r=%b iresp=%b want 1 0", c, pmem_read, i_resp); end
    end
    tick(); // cycle 5: memory responds
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_A;
    #1;
    n_tests++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin n_fail++; $display("FAIL ifill_resp: got i=%b d=%b want 1 0", i_resp, d_resp); end
    n_tests++; if (i_rdata !== PAT_A) begin n_fail++; $display("FAIL ifill_rdata: got %h want %h", i_rdata, PAT_A); end
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    #1;
    n_tests++; if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin n_fail++; $display("FAIL ifill_done: got r=%b iresp=%b want 0 0", pmem_read, i_resp); end
    n_tests++; if (o_dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL ifill_idle: got %0d want %0d", o_dbg_state, ST_IDLE); end
    tick();
  endtask

  // Write-back, plus address/data change while busy must not disturb the latched command.
  task automatic test_d_write_stable();
    d_write   = 1'b1;
    d_address = 32'h0000_2000;
    d_wdata   = PAT_B;
    tick();
    n_tests++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL dwr_cmd: got r=%b w=%b want r=0 w=1", pmem_read, pmem_write); end
    n_tests++; if (pmem_wdata !== PAT_B) begin n_fail++; $display("FAIL dwr_wdata: got %h want %h", pmem_wdata, PAT_B); end
    n_tests++; if (o_dbg_state !== ST_D) begin n_fail++; $display("FAIL dwr_state: got %0d want %0d", o_dbg_state, ST_D); end
    d_address = 32'h0000_3000;
    d_wdata   = PAT_C;
    tick();
    tick();
    n_tests++; if (pmem_address !== 32'h0000_2000) begin n_fail++; $display("FAIL dwr_addr_hold: got %h want 00002000", pmem_address); end
    n_tests++; if (pmem_wdata !== PAT_B || pmem_write !== 1'b1) begin n_fail++; $display("FAIL dwr_data_hold: got w=%b data=%h want 1 %h", pmem_write, pmem_wdata, PAT_B); end
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_C;
    #1;
    n_tests++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin n_fail++; $display("FAIL dwr_resp: got d=%b i=%b want 1 0", d_resp, i_resp); end
    n_tests++; if (pmem_address !== 32'h0000_2000) begin n_fail++; $display("FAIL dwr_addr_resp: got %h want 00002000", pmem_address); end
    tick();
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    #1;
    n_tests++; if (pmem_write !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL dwr_done: got w=%b dresp=%b want 0 0", pmem_write, d_resp); end
    tick();
  endtask

  task automatic test_spurious_resp();
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_A;
    #1;
    n_tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL spur_resp: got i=%b d=%b want 0 0", i_resp, d_resp); end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_tests++; if (o_dbg_state !== ST_IDLE || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL spur_state: got st=%0d r=%b w=%b want 0 0 0", o_dbg_state, pmem_read, pmem_write); end
    tick();
  endtask

  // Both clients held from reset: grants must go D, I, D with 2-cycle turnaround.
  task automatic test_back_to_back();
    int cnt;
    logic [AW-1:0] exp_addr;
    logic          exp_is_d;
    rst       = 1'b1;
    i_read    = 1'b1;
    i_address = 32'h0000_0100;
    d_read    = 1'b1;
    d_address = 32'h0000_0200;
    tick();
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0200);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      cnt = 0;
      do begin
        tick();
        pmem_resp = 1'b0;
        cnt++;
      end while (!(pmem_read || pmem_write) && cnt < 20);
      exp_addr = exp_q.pop_front();
      exp_is_d = (exp_addr == 32'h0000_0200);
      n_tests++; if (cnt != ((g == 0) ? 1 : 2)) begin n_fail++; $display("FAIL rr_latency g%0d: got %0d cycles want %0d", g, cnt, (g == 0) ? 1 : 2); end
      n_tests++; if (pmem_address !== exp_addr) begin n_fail++; $display("FAIL rr_order g%0d: got %h want %h", g, pmem_address, exp_addr); end
      n_tests++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL rr_cmd g%0d: got r=%b w=%b want 1 0", g, pmem_read, pmem_write); end
      tick();
      pmem_resp  = 1'b1;
      pmem_rdata = exp_is_d ? PAT_B : PAT_A;
      #1;
      n_tests++; if (d_resp !== exp_is_d || i_resp !== !exp_is_d) begin n_fail++; $display("FAIL rr_resp g%0d: got i=%b d=%b want i=%b d=%b", g, i_resp, d_resp, !exp_is_d, exp_is_d); end
    end
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    d_read    = 1'b0;
    tick();
    n_tests++; if (o_dbg_state !== ST_IDLE || pmem_read !== 1'b0) begin n_fail++; $display("FAIL rr_end: got st=%0d r=%b want 0 0", o_dbg_state, pmem_read); end
  endtask

  task automatic test_reset_mid();
    i_read    = 1'b1;
    i_address = 32'h0000_4000;
    tick();
    n_tests++; if (pmem_read !== 1'b1 || o_dbg_state !== ST_I) begin n_fail++; $display("FAIL rstmid_busy: got r=%b st=%0d want 1 %0d", pmem_read, o_dbg_state, ST_I); end
    tick();
    rst       = 1'b1;
    pmem_resp = 1'b1;
    #1;
    n_tests++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_drop: got %b want 0", pmem_read); end
    n_tests++; if (i_resp !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp: got %b want 0", i_resp); end
    tick();
    rst = 1'b0; // stale memory response still present in the first IDLE cycle
    #1;
    n_tests++; if (i_resp !== 1'b0 || o_dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_stale: got iresp=%b st=%0d want 0 0", i_resp, o_dbg_state); end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_4000) begin n_fail++; $display("FAIL rstmid_regrant: got r=%b a=%h want 1 00004000", pmem_read, pmem_address); end
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_C;
    #1;
    n_tests++; if (i_resp !== 1'b1 || i_rdata !== PAT_C) begin n_fail++; $display("FAIL rstmid_complete: got iresp=%b data=%h want 1 %h", i_resp, i_rdata, PAT_C); end
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_i_fill();
    test_d_write_stable();
    test_spurious_resp();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
